// File: rtl/fas_pkg.sv
// Shared types and sizes for the serial FFT peak detector.
// A bin is a packed {re, im} pair of signed Q8.8 values.
package fas_pkg;
   localparam int N_BINS = 16;
   localparam int DW     = 16;
   localparam int MAG_W  = 2 * DW;
   localparam int IDX_W  = $clog2(N_BINS);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SCAN   = 2'd1;
   localparam logic [1:0] REPORT = 2'd2;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } bin_t;
endpackage

// File: rtl/bin_mag_sq.sv
// Combinational squared magnitude of one bin: re^2 + im^2 as an unsigned MAG_W value.
module bin_mag_sq
   import fas_pkg::*;
(
   input  bin_t             bin,
   output logic [MAG_W-1:0] mag
);
   logic signed [DW-1:0]    re;
   logic signed [DW-1:0]    im;
   logic signed [MAG_W-1:0] re_x;
   logic signed [MAG_W-1:0] im_x;
   logic signed [MAG_W-1:0] re_sq;
   logic signed [MAG_W-1:0] im_sq;

   // Each square is at most 2^30, so the unsigned sum (max 2^31) cannot wrap.
   always_comb begin
      re    = bin.re;
      im    = bin.im;
      re_x  = {{DW{re[DW-1]}}, re};
      im_x  = {{DW{im[DW-1]}}, im};
      re_sq = re_x * re_x;
      im_sq = im_x * im_x;
      mag   = $unsigned(re_sq) + $unsigned(im_sq);
   end
endmodule

// File: rtl/fft_peak_detect.sv
// Captures a 16-bin spectrum and scans it one bin per cycle through a single
// squared-magnitude unit, reporting the strongest bin index and its magnitude.
module fft_peak_detect
   import fas_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fft_valid,
   input  logic [MAG_W-1:0]  fft_d0,
   input  logic [MAG_W-1:0]  fft_d1,
   input  logic [MAG_W-1:0]  fft_d2,
   input  logic [MAG_W-1:0]  fft_d3,
   input  logic [MAG_W-1:0]  fft_d4,
   input  logic [MAG_W-1:0]  fft_d5,
   input  logic [MAG_W-1:0]  fft_d6,
   input  logic [MAG_W-1:0]  fft_d7,
   input  logic [MAG_W-1:0]  fft_d8,
   input  logic [MAG_W-1:0]  fft_d9,
   input  logic [MAG_W-1:0]  fft_d10,
   input  logic [MAG_W-1:0]  fft_d11,
   input  logic [MAG_W-1:0]  fft_d12,
   input  logic [MAG_W-1:0]  fft_d13,
   input  logic [MAG_W-1:0]  fft_d14,
   input  logic [MAG_W-1:0]  fft_d15,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  freq,
   output logic [MAG_W-1:0]  peak_mag,
   output logic              overrun
);
   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] run_idx_q, run_idx_d;
   logic [MAG_W-1:0] run_max_q, run_max_d;
   logic [IDX_W-1:0] freq_q, freq_d;
   logic [MAG_W-1:0] peak_q, peak_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;
   logic             load;
   bin_t             frame_in [N_BINS];
   bin_t             frame_q  [N_BINS];
   bin_t             cur_bin;
   logic [MAG_W-1:0] mag;
   logic             cmp_gt;
   logic [MAG_W-1:0] best_max;
   logic [IDX_W-1:0] best_idx;

   always_comb begin
      frame_in[0]  = fft_d0;   frame_in[1]  = fft_d1;
      frame_in[2]  = fft_d2;   frame_in[3]  = fft_d3;
      frame_in[4]  = fft_d4;   frame_in[5]  = fft_d5;
      frame_in[6]  = fft_d6;   frame_in[7]  = fft_d7;
      frame_in[8]  = fft_d8;   frame_in[9]  = fft_d9;
      frame_in[10] = fft_d10;  frame_in[11] = fft_d11;
      frame_in[12] = fft_d12;  frame_in[13] = fft_d13;
      frame_in[14] = fft_d14;  frame_in[15] = fft_d15;
   end

   assign cur_bin = frame_q[idx_q];

   bin_mag_sq u_mag (
      .bin (cur_bin),
      .mag (mag)
   );

   // Strict compare: on a tie the earlier (lower) index is kept.
   assign cmp_gt   = (mag > run_max_q);
   assign best_max = cmp_gt ? mag   : run_max_q;
   assign best_idx = cmp_gt ? idx_q : run_idx_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      run_idx_d = run_idx_q;
      run_max_d = run_max_q;
      freq_d    = freq_q;
      peak_d    = peak_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      load      = 1'b0;
      case (state_q)
         SCAN: begin
            run_max_d = best_max;
            run_idx_d = best_idx;
            idx_d     = idx_q + IDX_W'(1);
            overrun_d = fft_valid;
            if (idx_q == IDX_W'(N_BINS - 1)) begin
               state_d = REPORT;
               freq_d  = best_idx;
               peak_d  = best_max;
               done_d  = 1'b1;
            end
         end
         default: begin
            // IDLE and REPORT both accept a new frame, allowing back-to-back scans.
            if (fft_valid) begin
               load      = 1'b1;
               idx_d     = '0;
               run_idx_d = '0;
               run_max_d = '0;
               state_d   = SCAN;
            end else begin
               state_d   = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         freq_q    <= '0;
         peak_q    <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         freq_q    <= freq_d;
         peak_q    <= peak_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   // Datapath state is always initialised on frame acceptance, so it needs no reset.
   always_ff @(posedge clk) begin
      run_idx_q <= run_idx_d;
      run_max_q <= run_max_d;
      if (load) frame_q <= frame_in;
   end

   assign busy     = (state_q == SCAN);
   assign done     = done_q;
   assign freq     = freq_q;
   assign peak_mag = peak_q;
   assign overrun  = overrun_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: expected results are queued when a frame
// is accepted and compared when done pulses.
module tb_fft_peak_detect;
   logic        clk = 1'b0;
   logic        rst;
   logic        fft_valid;
   logic [31:0] fd [16];
   logic        busy, done, overrun;
   logic [3:0]  freq;
   logic [31:0] peak_mag;

   typedef struct {
      logic [3:0]  f;
      logic [31:0] m;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] fr [16];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   fft_peak_detect dut (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),   .fft_d3(fd[3]),
      .fft_d4(fd[4]),   .fft_d5(fd[5]),   .fft_d6(fd[6]),   .fft_d7(fd[7]),
      .fft_d8(fd[8]),   .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
      .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
      .busy(busy), .done(done), .freq(freq), .peak_mag(peak_mag), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 16; i++) fr[i] = 32'h0;
   endtask

   // Reference peak search over fr: strict greater-than keeps the lowest index on ties.
   task automatic model(output logic [3:0] f, output logic [31:0] m);
      longint best = 0;
      f = 4'd0;
      for (int i = 0; i < 16; i++) begin
         longint re = longint'($signed(fr[i][31:16]));
         longint im = longint'($signed(fr[i][15:0]));
         longint mg = re * re + im * im;
         if (mg > best) begin
            best = mg;
            f    = 4'(i);
         end
      end
      m = best[31:0];
   endtask

   // Call at a negedge: presents fr with fft_valid and queues the expected result.
   task automatic send(input logic [3:0] ef, input logic [31:0] em);
      exp_t e;
      e.f = ef;
      e.m = em;
      fd = fr;
      fft_valid = 1'b1;
      sb.push_back(e);
   endtask

   task automatic send_model();
      logic [3:0]  ef;
      logic [31:0] em;
      model(ef, em);
      send(ef, em);
   endtask

   task automatic wait_done(output int n, output int busy_n, output int ov, input int limit);
      n = -1;
      busy_n = 0;
      ov = 0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         fft_valid = 1'b0;
         if (busy) busy_n++;
         if (overrun) ov++;
         if (done) begin
            n = k;
            break;
         end
      end
      if (n < 0) chk("done_timeout", 64'(n), 64'(limit));
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("freq", 64'(freq), 64'(e.f));
            chk("peak_mag", 64'(peak_mag), 64'(e.m));
         end
         if (overrun) chk("done_with_overrun", 1, 0);
      end
   end

   initial begin
      int n, bn, ov;
      rst = 1'b1;
      fft_valid = 1'b0;
      clear_frame();
      fd = fr;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_freq", 64'(freq), 0);
      chk("rst_peak", 64'(peak_mag), 0);
      chk("rst_overrun", 64'(overrun), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single dominant bin: latency, busy length and pulse width.
      clear_frame();
      fr[5] = 32'h0100_0000;
      send(4'd5, 32'h0001_0000);
      wait_done(n, bn, ov, 40);
      chk("t1_latency", 64'(n), 17);
      chk("t1_busy_cycles", 64'(bn), 16);
      @(negedge clk);
      chk("t1_done_one_cycle", 64'(done), 0);
      chk("t1_freq_held", 64'(freq), 5);
      chk("t1_busy_after", 64'(busy), 0);

      // Tie between bins 3 and 9.
      clear_frame();
      fr[3] = 32'h0200_0000;
      fr[9] = 32'h0000_0200;
      send(4'd3, 32'h0004_0000);
      wait_done(n, bn, ov, 40);
      @(negedge clk);

      // Extremes: full-scale negative in the last bin, then all-zero.
      clear_frame();
      fr[15] = 32'h8000_8000;
      send(4'd15, 32'h8000_0000);
      wait_done(n, bn, ov, 40);
      @(negedge clk);
      clear_frame();
      send(4'd0, 32'h0);
      wait_done(n, bn, ov, 40);
      chk("t3_zero_seen", 64'(n), 17);
      @(negedge clk);

      // Frame arriving mid-scan is dropped with an overrun pulse.
      clear_frame();
      fr[2] = 32'h0300_0000;
      send(4'd2, 32'h0009_0000);
      @(negedge clk);
      fft_valid = 1'b0;
      repeat (5) @(negedge clk);
      clear_frame();
      fr[7] = 32'h7fff_7fff;
      fd = fr;
      fft_valid = 1'b1;
      @(negedge clk);
      fft_valid = 1'b0;
      chk("t4_overrun", 64'(overrun), 1);
      chk("t4_busy", 64'(busy), 1);
      @(negedge clk);
      chk("t4_overrun_pulse", 64'(overrun), 0);
      wait_done(n, bn, ov, 40);
      chk("t4_done_seen", 64'(n > 0), 1);
      repeat (25) @(negedge clk);
      chk("t4_sb_empty", 64'(sb.size()), 0);

      // Back-to-back: second frame presented in the REPORT cycle.
      clear_frame();
      fr[11] = 32'h0000_0400;
      send(4'd11, 32'h0010_0000);
      wait_done(n, bn, ov, 40);
      clear_frame();
      fr[4] = 32'h0050_ffb0;
      send(4'd4, 32'h0000_3200);
      wait_done(n, bn, ov, 40);
      chk("t5_spacing", 64'(n), 17);
      chk("t5_no_overrun", 64'(ov), 0);
      @(negedge clk);

      // Reset in the middle of a scan.
      clear_frame();
      fr[6] = 32'h0100_0100;
      send(4'd6, 32'h0002_0000);
      @(negedge clk);
      fft_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_busy", 64'(busy), 0);
      chk("t6_done", 64'(done), 0);
      chk("t6_freq", 64'(freq), 0);
      chk("t6_peak", 64'(peak_mag), 0);
      chk("t6_overrun", 64'(overrun), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      clear_frame();
      fr[13] = 32'hff00_0000;
      send(4'd13, 32'h0001_0000);
      wait_done(n, bn, ov, 40);
      chk("t6_post_latency", 64'(n), 17);
      @(negedge clk);

      // Random frames against the reference search.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) fr[i] = $urandom;
         send_model();
         wait_done(n, bn, ov, 40);
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("final_sb_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
